seq_detect_1011: RTL and testbench

Serial sequence detector: the receiving end for the team's 4-state bit-pattern generators. Samples a qualified serial bit stream, detects the pattern 1011 (first-received bit first) with a 4-state FSM, emits a one-cycle registered hit pulse, and maintains a saturating hit counter readable by control logic. It sits directly downstream of a pattern source, or any serial link, in the state-machine lab chain.

---
 rtl/seq_detect_pkg.sv | 22 ++
 rtl/sat_counter.sv | 22 ++
 rtl/seq_detect_1011.sv | 75 +++++++
 tb/tb_seq_detect_1011.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// Shared types and constants for the 1011 serial sequence detector.
package seq_detect_pkg;

  localparam int STATE_W = 2;
  localparam logic [3:0] PATTERN = 4'b1011;

  // Encoding equals the number of pattern bits matched so far.
  typedef enum logic [STATE_W-1:0] {
    S_IDLE = 2'b00,
    S_1    = 2'b01,
    S_10   = 2'b10,
    S_101  = 2'b11
  } state_t;

  // Bit the pattern expects next, given how many bits are already matched.
  function automatic logic pattern_bit(input state_t s);
    logic [1:0] idx;
    idx = 2'd3 - s;
    return PATTERN[idx];
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: sticks at all-ones, synchronous clear, async active-low reset.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] cnt_o
);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_o <= '0;
    end else if (clr_i) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != {WIDTH{1'b1}})) begin
      cnt_o <= cnt_o + 1'b1;
    end
  end

endmodule

// File: rtl/seq_detect_1011.sv
// Serial 1011 detector with registered hit pulse and saturating hit counter.
// Define SEQ_DETECT_OVERLAP_EN for overlapping detection (trailing 1 reused).
module seq_detect_1011
  import seq_detect_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               bit_i,
  input  logic               bit_vld_i,
  input  logic               clr_i,
  output logic               hit_o,
  output logic [CNT_W-1:0]   hit_cnt_o,
  output logic [STATE_W-1:0] state_o
);

`ifdef SEQ_DETECT_OVERLAP_EN
  localparam state_t AFTER_HIT = S_1;
`else
  localparam state_t AFTER_HIT = S_IDLE;
`endif

  state_t state_q;
  logic   hit_now;
  logic   bit_match;

  assign bit_match = (bit_i == pattern_bit(state_q));
  // A clear in the same cycle swallows the completing bit.
  assign hit_now   = bit_vld_i && !clr_i && (state_q == S_101) && bit_match;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      hit_o   <= 1'b0;
    end else begin
      hit_o <= hit_now;
      if (clr_i) begin
        state_q <= S_IDLE;
      end else if (bit_vld_i) begin
        if (bit_match) begin
          case (state_q)
            S_IDLE:  state_q <= S_1;
            S_1:     state_q <= S_10;
            S_10:    state_q <= S_101;
            S_101:   state_q <= AFTER_HIT;
            default: state_q <= S_IDLE;
          endcase
        end else begin
          // Fall back to the longest suffix that is still a pattern prefix.
          case (state_q)
            S_IDLE:  state_q <= S_IDLE;
            S_1:     state_q <= S_1;
            S_10:    state_q <= S_IDLE;
            S_101:   state_q <= S_10;
            default: state_q <= S_IDLE;
          endcase
        end
      end
    end
  end

  assign state_o = state_q;

  sat_counter #(
    .WIDTH(CNT_W)
  ) u_hit_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .inc_i   (hit_now),
    .clr_i   (clr_i),
    .cnt_o   (hit_cnt_o)
  );

endmodule

// File: tb/tb_seq_detect_1011.sv
// Self-checking bench for seq_detect_1011: sliding-window model plus directed scenarios.
module tb_seq_detect_1011;

  localparam int CNT_W   = 8;
  localparam int CNT_W_N = 2;

`ifdef SEQ_DETECT_OVERLAP_EN
  localparam bit         OVERLAP     = 1'b1;
  localparam logic [6:0] EXP_OVL_HIT = 7'b0001001;
  localparam int         EXP_OVL_CNT = 2;
`else
  localparam bit         OVERLAP     = 1'b0;
  localparam logic [6:0] EXP_OVL_HIT = 7'b0001000;
  localparam int         EXP_OVL_CNT = 1;
`endif

  logic clk_i     = 1'b0;
  logic rst_n_i   = 1'b0;
  logic bit_i     = 1'b0;
  logic bit_vld_i = 1'b0;
  logic clr_i     = 1'b0;

  logic               hit_w, hit_n;
  logic [CNT_W-1:0]   cnt_w;
  logic [CNT_W_N-1:0] cnt_n;
  logic [1:0]         state_w, state_n;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  seq_detect_1011 #(.CNT_W(CNT_W)) dut_wide (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .bit_i     (bit_i),
    .bit_vld_i (bit_vld_i),
    .clr_i     (clr_i),
    .hit_o     (hit_w),
    .hit_cnt_o (cnt_w),
    .state_o   (state_w)
  );

  seq_detect_1011 #(.CNT_W(CNT_W_N)) dut_narrow (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .bit_i     (bit_i),
    .bit_vld_i (bit_vld_i),
    .clr_i     (clr_i),
    .hit_o     (hit_n),
    .hit_cnt_o (cnt_n),
    .state_o   (state_n)
  );

  // Model: remember the last valid bits; a hit is the window reading 1011,
  // and the state is the longest window suffix that is a pattern prefix.
  logic [3:0] pat = 4'b1011;
  bit         win[$];
  bit         m_hit   = 1'b0;
  int         m_state = 0;
  int         m_cnt_w = 0;
  int         m_cnt_n = 0;

  function automatic int suffix_len();
    for (int k = 3; k >= 1; k--) begin
      if (win.size() >= k) begin
        bit ok = 1'b1;
        for (int j = 0; j < k; j++)
          if (win[win.size() - k + j] != pat[3 - j]) ok = 1'b0;
        if (ok) return k;
      end
    end
    return 0;
  endfunction

  always @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i || clr_i) begin
      win.delete();
      m_hit   = 1'b0;
      m_state = 0;
      m_cnt_w = 0;
      m_cnt_n = 0;
    end else if (bit_vld_i) begin
      win.push_back(bit_i);
      if (win.size() > 4) void'(win.pop_front());
      m_hit = (win.size() == 4) && (suffix_len() == 3 || 1'b1) &&
              win[0] == pat[3] && win[1] == pat[2] && win[2] == pat[1] && win[3] == pat[0];
      if (m_hit) begin
        if (m_cnt_w < (1 << CNT_W) - 1)   m_cnt_w++;
        if (m_cnt_n < (1 << CNT_W_N) - 1) m_cnt_n++;
        if (!OVERLAP) win.delete();
      end
      m_state = suffix_len();
    end else begin
      m_hit = 1'b0;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk_i) begin
    checkOutput("model_hit_w",   hit_w,   m_hit);
    checkOutput("model_hit_n",   hit_n,   m_hit);
    checkOutput("model_state_w", state_w, m_state);
    checkOutput("model_state_n", state_n, m_state);
    checkOutput("model_cnt_w",   cnt_w,   m_cnt_w);
    checkOutput("model_cnt_n",   cnt_n,   m_cnt_n);
  end

  task automatic applyStimulus(input logic b, input logic v, input logic c);
    bit_i     = b;
    bit_vld_i = v;
    clr_i     = c;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    int hits;
    int exp_n[5] = '{1, 2, 3, 3, 3};

    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("reset_state", state_w, 0);
    checkOutput("reset_hit",   hit_w,   0);
    checkOutput("reset_cnt",   cnt_w,   0);
    rst_n_i = 1'b1;

    $display("[TB] reset mid-pattern");
    applyStimulus(1, 1, 0);
    applyStimulus(0, 1, 0);
    applyStimulus(1, 1, 0);
    checkOutput("mid_state_101", state_w, 3);
    bit_vld_i = 1'b0;
    #2 rst_n_i = 1'b0;
    #1;
    checkOutput("async_rst_state", state_w, 0);
    @(posedge clk_i);
    #1 rst_n_i = 1'b1;
    applyStimulus(1, 1, 0);
    checkOutput("post_rst_hit",   hit_w,   0);
    checkOutput("post_rst_cnt",   cnt_w,   0);
    checkOutput("post_rst_state", state_w, 1);

    $display("[TB] stream 1011011");
    applyStimulus(0, 0, 1);
    for (int i = 6; i >= 0; i--) begin
      logic [6:0] stream = 7'b1011011;
      applyStimulus(stream[i], 1, 0);
      checkOutput($sformatf("ovl_hit_bit%0d", 7 - i), hit_w, EXP_OVL_HIT[i]);
    end
    checkOutput("ovl_cnt",   cnt_w,   EXP_OVL_CNT);
    checkOutput("ovl_state", state_w, 1);

    $display("[TB] gapped input");
    applyStimulus(0, 0, 1);
    hits = 0;
    for (int i = 3; i >= 0; i--) begin
      applyStimulus(pat[i], 1, 0);
      hits += int'(hit_w);
      if (i == 0) checkOutput("gap_hit_after_4th", hit_w, 1);
      else
        for (int g = 0; g < 3; g++) begin
          applyStimulus(g[0] ^ pat[i], 0, 0);
          hits += int'(hit_w);
        end
    end
    applyStimulus(1, 0, 0);
    checkOutput("gap_hit_one_cycle", hit_w, 0);
    hits += int'(hit_w);
    checkOutput("gap_hit_total", hits, 1);
    checkOutput("gap_cnt", cnt_w, 1);

    $display("[TB] saturation");
    applyStimulus(0, 0, 1);
    hits = 0;
    for (int p = 0; p < 5; p++) begin
      for (int i = 3; i >= 0; i--) begin
        applyStimulus(pat[i], 1, 0);
        hits += int'(hit_n);
      end
      checkOutput($sformatf("sat_cnt_n_%0d", p), cnt_n, exp_n[p]);
      checkOutput($sformatf("sat_cnt_w_%0d", p), cnt_w, p + 1);
      applyStimulus(0, 1, 0);
      hits += int'(hit_n);
      applyStimulus(0, 1, 0);
      hits += int'(hit_n);
    end
    checkOutput("sat_hit_pulses", hits, 5);

    $display("[TB] clear collision");
    applyStimulus(1, 1, 0);
    applyStimulus(0, 1, 0);
    applyStimulus(1, 1, 0);
    applyStimulus(1, 1, 1);
    checkOutput("clr_hit",   hit_w,   0);
    checkOutput("clr_state", state_w, 0);
    checkOutput("clr_cnt",   cnt_w,   0);
    for (int i = 3; i >= 0; i--) applyStimulus(pat[i], 1, 0);
    checkOutput("clr_then_hit", hit_w, 1);
    checkOutput("clr_then_cnt", cnt_w, 1);

    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
